johnson_decoder_checker: RTL and testbench
==========================================

# johnson_decoder_checker

Receive-side companion to the pipelined Johnson counter: samples an N-bit Johnson-coded word each valid cycle, decodes it to its binary phase index (0..2N-1), flags illegal codes and out-of-sequence steps, and runs a HUNT/CONFIRM/LOCKED FSM to declare sequence lock. Results are pipelined STAGES deep to match the generator's output pipeline. It is used to check counter-driven phase/timing buses crossing block boundaries.

## Interface
- N, 4: Johnson word width, N >= 2; phase index width CW = $clog2(2N).
- STAGES, 2: output pipeline depth, >= 1.
- LOCK_COUNT, 3: consecutive correct successors needed in CONFIRM to enter LOCKED, >= 1.
- MISS_LIMIT, 2: consecutive bad samples in LOCKED that drop to HUNT, >= 1.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- din_valid  in  1  din is a sample this cycle.
- din  in  N  Johnson-coded word.
- clear_errors  in  1  synchronous clear of err_count.
- count_valid  out  1  pipelined: sample was valid and legal.
- count_out  out  CW  pipelined decoded phase index; 0 when not count_valid.
- code_error  out  1  pipelined: valid sample was an illegal code.
- seq_error  out  1  pipelined: legal sample was not the expected successor (LOCKED only).
- locked  out  1  pipelined: FSM state after this sample is LOCKED.
- err_count  out  16  saturating count of samples with code_error or seq_error.

## Operation
- Sequence: successor of q is {~q[0], q[N-1:1]}; from 0 it runs 0000,1000,1100,1110,1111,0111,0011,0001 (N=4), then wraps.
- Legality: legal iff the number of adjacent bit pairs (din[i], din[i+1]), i=0..N-2, that differ is <= 1. Exactly 2N legal codes.
- Decode: p = popcount(din); index = p if din[N-1]==1 or din==0, else 2N-p. Index arithmetic is modulo 2N; the successor of 2N-1 is 0.
- Registers: ref (CW bits, last accepted index), run counter, miss counter, state.
- Samples with din_valid=0 change no state and produce a pipeline bubble: all flags 0, count_valid 0, locked carries the current state.
- HUNT: legal sample sets ref=index, run=0, and moves to CONFIRM. An illegal sample asserts code_error and stays in HUNT.
- CONFIRM:
  - Legal sample with index == ref+1: ref advances and run increments. When run reaches LOCK_COUNT, move to LOCKED with miss=0.
  - Legal sample with the wrong index: ref=index, run=0, stay in CONFIRM. No seq_error.
  - Illegal sample: code_error asserts and the FSM returns to HUNT.
- LOCKED:
  - Expected successor: ref advances, miss=0.
  - Legal wrong index: seq_error asserts, ref resyncs to the received index, miss increments.
  - Illegal sample: code_error asserts, ref advances as if predicted, miss increments.
  - When miss reaches MISS_LIMIT, move to HUNT. The locked flag for that sample is 0.
- err_count: increments by 1 per sample with code_error or seq_error and saturates at 16'hFFFF. clear_errors forces 0 and wins over a same-cycle increment; that event is not counted.

## Timing
- Latency: a sample on din in cycle t produces count_valid/count_out/code_error/seq_error/locked in cycle t+STAGES.
- err_count changes in the same cycle the corresponding flag is visible.
- Throughput: one sample per cycle, no stalls, no backpressure.
- FSM state updates at the edge that samples din. The pipeline delays only the reported values.
- Reset: all outputs are 0 immediately (asynchronous). state=HUNT; ref, run, miss and all pipeline stages are cleared. Samples in flight at reset are discarded. The first sample after reset deassertion is treated as a HUNT input.
- clear_errors takes effect at the next rising edge and is independent of the FSM.

## Test plan
1. Reset; N=4, STAGES=2, LOCK_COUNT=3. Send 0000,1000,1100,1110,1111 back-to-back.
   - count_out 0,1,2,3,4 with count_valid 1, starting 2 cycles after the first sample.
   - locked first 1 on the result of 1110; err_count stays 0.
2. While locked, after 1111 send 0100, then 0011.
   - 0100: code_error=1, count_valid=0, err_count=1, locked stays 1.
   - 0011: index 6, no error (predicted ref=5 advanced to 6).
3. While locked, after 1100 send 1111, then 0111.
   - 1111: seq_error=1, count_out=4, err_count +1.
   - 0111: index 5, no error.
4. While locked, send two consecutive illegal codes (0100, 1010).
   - locked drops to 0 on the second.
   - Relock requires 4 further correct legal samples.
5. While locked, send 0001, idle 3 cycles with din_valid=0, then 0000.
   - No errors; count_out 7 then 0 (wrap); bubbles show count_valid=0 with locked=1.
6. Assert reset mid-stream: all outputs 0 asynchronously.
   - Separately, with err_count=5, assert clear_errors in the same cycle as an error sample: err_count=0 afterwards.
   - Force 65535 errors: err_count holds at 16'hFFFF.

Source files
------------

// File: rtl/johnson_decoder_checker_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// johnson_decoder_checker_if : sample/result bundle for the Johnson checker
// Rev 1.0
// ---------------------------------------------------------------------------
interface johnson_decoder_checker_if #(
   parameter int N  = 4,
   parameter int CW = $clog2(2 * N)
);
   logic          din_valid;
   logic [N-1:0]  din;
   logic          clear_errors;
   logic          count_valid;
   logic [CW-1:0] count_out;
   logic          code_error;
   logic          seq_error;
   logic          locked;
   logic [15:0]   err_count;

   modport master (
      output din_valid, din, clear_errors,
      input  count_valid, count_out, code_error, seq_error, locked, err_count
   );

   modport slave (
      input  din_valid, din, clear_errors,
      output count_valid, count_out, code_error, seq_error, locked, err_count
   );
endinterface
`default_nettype wire

// File: rtl/johnson_decoder_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// johnson_decoder_checker : decodes Johnson words, checks sequence, tracks lock
// Rev 1.0
// ---------------------------------------------------------------------------
module johnson_decoder_checker #(
   parameter int N          = 4,
   parameter int STAGES     = 2,
   parameter int LOCK_COUNT = 3,
   parameter int MISS_LIMIT = 2
) (
   input  wire logic                  clk,
   input  wire logic                  reset,
   johnson_decoder_checker_if.slave   bus
);
   localparam int CW = $clog2(2 * N);
   localparam int RW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(MISS_LIMIT + 1);
   // 2N may truncate to 0 in CW bits; the modular subtraction is still exact
   localparam logic [CW-1:0] TWO_N     = CW'(2 * N);
   localparam logic [CW-1:0] LAST_IDX  = CW'(2 * N - 1);
   localparam logic [RW-1:0] RUN_LOCK  = RW'(LOCK_COUNT);
   localparam logic [MW-1:0] MISS_DROP = MW'(MISS_LIMIT);

   typedef enum logic [1:0] {HUNT = 2'd0, CONFIRM = 2'd1, LOCKED = 2'd2} state_t;

   typedef struct packed {
      logic          valid;
      logic [CW-1:0] idx;
      logic          code_err;
      logic          seq_err;
      logic          locked;
   } res_t;

   state_t                 state_q, state_d;
   logic [CW-1:0]          ref_q, ref_d;
   logic [RW-1:0]          run_q, run_d;
   logic [MW-1:0]          miss_q, miss_d;
   logic [15:0]            err_q;
   res_t [STAGES-1:0]      pipe_q;
   res_t [STAGES-1:0]      pipe_in;

   logic [CW-1:0] pop, trans, idx, succ;
   logic [RW-1:0] run_inc;
   logic [MW-1:0] miss_inc;
   logic          legal, code_err, seq_err, err_inc;
   res_t          res0;

   always_comb begin
      pop   = '0;
      trans = '0;
      for (int i = 0; i < N; i++)     pop   = pop + CW'(bus.din[i]);
      for (int i = 0; i < N - 1; i++) trans = trans + CW'(bus.din[i] ^ bus.din[i+1]);
   end

   assign legal    = (trans <= CW'(1));
   assign idx      = (bus.din[N-1] | ~|bus.din) ? pop : (TWO_N - pop);
   assign succ     = (ref_q == LAST_IDX) ? '0 : ref_q + 1'b1;
   assign run_inc  = run_q + 1'b1;
   assign miss_inc = miss_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      run_d    = run_q;
      miss_d   = miss_q;
      code_err = 1'b0;
      seq_err  = 1'b0;
      if (bus.din_valid) begin
         code_err = ~legal;
         unique case (state_q)
            HUNT: begin
               if (legal) begin
                  ref_d   = idx;
                  run_d   = '0;
                  state_d = CONFIRM;
               end
            end
            CONFIRM: begin
               if (!legal) begin
                  state_d = HUNT;
               end else if (idx == succ) begin
                  ref_d = succ;
                  run_d = run_inc;
                  if (run_inc == RUN_LOCK) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  ref_d = idx;
                  run_d = '0;
               end
            end
            LOCKED: begin
               if (legal && idx == succ) begin
                  ref_d  = succ;
                  miss_d = '0;
               end else begin
                  // a corrupted code keeps the prediction; a wrong legal code resyncs
                  seq_err = legal;
                  ref_d   = legal ? idx : succ;
                  miss_d  = miss_inc;
                  if (miss_inc == MISS_DROP) state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      res0.valid    = bus.din_valid & legal;
      res0.idx      = (bus.din_valid & legal) ? idx : '0;
      res0.code_err = code_err;
      res0.seq_err  = seq_err;
      res0.locked   = (state_d == LOCKED);
      pipe_in[0]    = res0;
      for (int s = 1; s < STAGES; s++) pipe_in[s] = pipe_q[s-1];
   end

   // err_count moves on the edge that makes the matching flag visible
   assign err_inc = pipe_in[STAGES-1].code_err | pipe_in[STAGES-1].seq_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= HUNT;
         ref_q   <= '0;
         run_q   <= '0;
         miss_q  <= '0;
         pipe_q  <= '0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         ref_q   <= ref_d;
         run_q   <= run_d;
         miss_q  <= miss_d;
         pipe_q  <= pipe_in;
         if (bus.clear_errors)
            err_q <= '0;
         else if (err_inc && err_q != 16'hFFFF)
            err_q <= err_q + 16'd1;
      end
   end

   assign bus.count_valid = pipe_q[STAGES-1].valid;
   assign bus.count_out   = pipe_q[STAGES-1].idx;
   assign bus.code_error  = pipe_q[STAGES-1].code_err;
   assign bus.seq_error   = pipe_q[STAGES-1].seq_err;
   assign bus.locked      = pipe_q[STAGES-1].locked;
   assign bus.err_count   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_johnson_decoder_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_johnson_decoder_checker : directed vectors, N=4 STAGES=2 LOCK_COUNT=3
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_johnson_decoder_checker;
   logic clk = 1'b0;
   logic reset;

   johnson_decoder_checker_if #(.N(4)) bus_if ();

   johnson_decoder_checker #(
      .N(4), .STAGES(2), .LOCK_COUNT(3), .MISS_LIMIT(2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [3:0]  d;
      logic        clr;
      logic        cv;
      logic [2:0]  cnt;
      logic        ce;
      logic        se;
      logic        lk;
      logic [15:0] err;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [3:0] d, input logic clr, input logic cv,
                      input logic [2:0] cnt, input logic ce, input logic se, input logic lk,
                      input logic [15:0] err);
      vec_t e;
      e = '{v, d, clr, cv, cnt, ce, se, lk, err};
      tbl.push_back(e);
   endtask

   // present inputs at a falling edge, hold them across one rising edge
   task automatic drive(input logic v, input logic [3:0] d, input logic clr);
      bus_if.din_valid    = v;
      bus_if.din          = d;
      bus_if.clear_errors = clr;
      @(negedge clk);
   endtask

   task automatic check_vec(input string sec, input int i);
      check($sformatf("%s%0d.count_valid", sec, i), 32'(bus_if.count_valid), 32'(tbl[i].cv));
      check($sformatf("%s%0d.count_out", sec, i),   32'(bus_if.count_out),   32'(tbl[i].cnt));
      check($sformatf("%s%0d.code_error", sec, i),  32'(bus_if.code_error),  32'(tbl[i].ce));
      check($sformatf("%s%0d.seq_error", sec, i),   32'(bus_if.seq_error),   32'(tbl[i].se));
      check($sformatf("%s%0d.locked", sec, i),      32'(bus_if.locked),      32'(tbl[i].lk));
      check($sformatf("%s%0d.err_count", sec, i),   32'(bus_if.err_count),   32'(tbl[i].err));
   endtask

   // a result is visible one drive() after the drive() that follows its sample
   task automatic play(input string sec);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].d, tbl[i].clr);
         if (i > 0) check_vec(sec, i - 1);
      end
      drive(1'b0, 4'b0000, 1'b0);
      check_vec(sec, tbl.size() - 1);
      tbl.delete();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".count_valid"}, 32'(bus_if.count_valid), 32'd0);
      check({tag, ".count_out"},   32'(bus_if.count_out),   32'd0);
      check({tag, ".code_error"},  32'(bus_if.code_error),  32'd0);
      check({tag, ".seq_error"},   32'(bus_if.seq_error),   32'd0);
      check({tag, ".locked"},      32'(bus_if.locked),      32'd0);
      check({tag, ".err_count"},   32'(bus_if.err_count),   32'd0);
   endtask

   initial begin
      reset               = 1'b1;
      bus_if.din_valid    = 1'b0;
      bus_if.din          = 4'b0000;
      bus_if.clear_errors = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b0;

      // lock-up, then corrupted / out-of-order / lost-lock / wrap cases
      add(1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      add(1'b1, 4'b1000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 16'd0);
      add(1'b1, 4'b1100, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 16'd0);
      add(1'b1, 4'b1110, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 16'd0);
      add(1'b1, 4'b1111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b1, 16'd0);
      add(1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 16'd1);
      add(1'b1, 4'b0011, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 16'd1);
      add(1'b1, 4'b0001, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 16'd1);
      add(1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'd1);
      add(1'b1, 4'b1000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1, 16'd1);
      add(1'b1, 4'b1100, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 16'd1);
      add(1'b1, 4'b1111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 16'd2);
      add(1'b1, 4'b0111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 16'd2);
      add(1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b1, 16'd3);
      add(1'b1, 4'b1010, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd4);
      add(1'b1, 4'b0001, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 16'd4);
      add(1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'd4);
      add(1'b1, 4'b1110, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 16'd4);
      add(1'b1, 4'b1111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 16'd4);
      add(1'b1, 4'b0111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 16'd4);
      add(1'b1, 4'b0011, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 16'd4);
      add(1'b1, 4'b0001, 1'b0, 1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 16'd4);
      for (int k = 0; k < 3; k++)
         add(1'b0, 4'b0100, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 16'd4);
      add(1'b1, 4'b0000, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 16'd4);
      play("a");

      // asynchronous reset between clock edges
      #2;
      check("pre_reset.locked", 32'(bus_if.locked), 32'd1);
      reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // HUNT errors to 5, clear on the edge that would count the 6th
      for (int k = 1; k <= 5; k++)
         add(1'b1, 4'b0100, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'(k));
      add(1'b1, 4'b1010, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd0);
      add(1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      // illegal code in CONFIRM must restart from HUNT
      add(1'b1, 4'b1100, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 16'd0);
      add(1'b1, 4'b1101, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 16'd1);
      add(1'b1, 4'b1110, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 16'd1);
      add(1'b1, 4'b1111, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0, 16'd1);
      add(1'b1, 4'b0111, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 16'd1);
      add(1'b1, 4'b0011, 1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 16'd1);
      play("b");

      // saturation of err_count
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 65536; k++) drive(1'b1, 4'b0100, 1'b0);
      drive(1'b0, 4'b0000, 1'b0);
      drive(1'b0, 4'b0000, 1'b0);
      check("sat.err_count", 32'(bus_if.err_count), 32'h0000FFFF);
      drive(1'b1, 4'b1010, 1'b0);
      drive(1'b0, 4'b0000, 1'b0);
      check("sat_hold.code_error", 32'(bus_if.code_error), 32'd1);
      check("sat_hold.err_count", 32'(bus_if.err_count), 32'h0000FFFF);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
